// File: rtl/piso_register_nbit.sv
// Parallel-in serial-out register with a valid/ready load handshake and a stallable serial stream.
// A word is accepted in IDLE, or on the cycle its predecessor's final bit is consumed, so words can stream with no gap.
module piso_register_nbit #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] d,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         shift_en,
    output logic         sout,
    output logic         sout_valid,
    output logic         last
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic in_shift;
    logic at_last;
    logic accept;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = in_shift && (cnt_q == CNT_LAST);
    assign accept   = load_valid && load_ready;

    // Outputs are forced low while clr is held, independent of the registered state.
    assign load_ready = ~clr & (~in_shift | (at_last & shift_en));
    assign sout_valid = ~clr & in_shift;
    assign last       = ~clr & at_last;
    assign sout       = ~clr & in_shift & (MSB_FIRST ? sreg_q[N-1] : sreg_q[0]);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = SHIFT;
            sreg_d  = d;
            cnt_d   = '0;
        end else if (in_shift && shift_en) begin
            sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        sreg_q  <= sreg_d;
        cnt_q   <= cnt_d;
    end

endmodule
